ham_ser_dec: RTL and testbench

HAM_SER_DEC -- requirements
Module: ham_ser_dec

---
 rtl/ham_ser_dec.sv | 147 ++++++++++++++
 tb/tb_ham_ser_dec.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham_ser_dec.sv
// ham_ser_dec: serial (17,12) even-parity Hamming decoder.
// Bits arrive LSB-first as codeword positions 1..17. A single-cycle CHECK
// state computes the syndrome and corrects single-bit errors. The result is
// then held until the consumer completes the out_valid/out_ready handshake.
module ham_ser_dec #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sin_valid,
    input  logic             sin_bit,
    output logic             sin_ready,
    input  logic             frame_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      esti_bits,
    output logic [4:0]       syndrome,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic [CNT_W-1:0] corr_cnt
);

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [16:0] r_shift;
    logic        w_last;
    logic [4:0]  w_syn;
    logic        w_corr;
    logic        w_uncorr;
    logic [16:0] w_fixed;
    logic [11:0] w_info;

    // Pulls the 12 information bits out of codeword positions
    // 3,5,6,7,9..15,17. Bit index is position minus one.
    function automatic logic [11:0] extractInfo(input logic [16:0] cw);
        return {cw[16], cw[14], cw[13], cw[12], cw[11], cw[10],
                cw[9],  cw[8],  cw[6],  cw[5],  cw[4],  cw[2]};
    endfunction

    // The 17th accepted bit ends the frame. A concurrent frame_clr wins, so
    // that frame is discarded rather than checked.
    assign w_last = (r_state == RECV) && sin_valid && !frame_clr && (r_cnt == 5'd16);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RECV;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the handshake outputs decoded from the state.
    always_comb begin
        w_next    = r_state;
        sin_ready = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            RECV: begin
                sin_ready = 1'b1;
                if (w_last) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = RECV;
                end
            end
            default: begin
                w_next = RECV;
            end
        endcase
    end

    // Capture serial bits at the current position. frame_clr restarts the
    // frame and takes priority over a bit arriving on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 5'd0;
            r_shift <= 17'd0;
        end else if (r_state == RECV) begin
            if (frame_clr) begin
                r_cnt   <= 5'd0;
                r_shift <= 17'd0;
            end else if (sin_valid) begin
                r_shift[r_cnt] <= sin_bit;
                r_cnt          <= (r_cnt == 5'd16) ? 5'd0 : r_cnt + 5'd1;
            end
        end
    end

    // Syndrome: XOR of the position numbers of every received 1 bit. This
    // is equivalent to taking per-bit parity over each position group.
    always_comb begin
        w_syn = 5'd0;
        for (int k = 1; k <= 17; k++) begin
            if (r_shift[k-1]) begin
                w_syn = w_syn ^ 5'(k);
            end
        end
    end

    // Correction: syndromes 1..17 name the bad position, even when it holds
    // parity. Syndromes 18..31 cannot name a position, so the raw data passes.
    always_comb begin
        w_corr   = (w_syn != 5'd0) && (w_syn <= 5'd17);
        w_uncorr = (w_syn >= 5'd18);
        w_fixed  = r_shift;
        if (w_corr) begin
            w_fixed[w_syn - 5'd1] = ~r_shift[w_syn - 5'd1];
        end
        w_info = extractInfo(w_fixed);
    end

    // Register the decode results in CHECK and hold them until the next
    // CHECK. The corrected-frame counter saturates at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            esti_bits  <= 12'd0;
            syndrome   <= 5'd0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
            corr_cnt   <= '0;
        end else if (r_state == CHECK) begin
            esti_bits  <= w_info;
            syndrome   <= w_syn;
            err_corr   <= w_corr;
            err_uncorr <= w_uncorr;
            if (w_corr && (corr_cnt != {CNT_W{1'b1}})) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ham_ser_dec.sv
// tb_ham_ser_dec: table-driven, directed and randomized checks for ham_ser_dec.
module tb_ham_ser_dec;

    typedef struct packed {
        logic [11:0] esti;
        logic [4:0]  syn;
        logic        corr;
        logic        unc;
    } result_t;

    typedef struct {
        string       name;
        logic [16:0] frame;
        result_t     exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sin_valid;
    logic        sin_bit;
    logic        sin_ready;
    logic        frame_clr;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] esti_bits;
    logic [4:0]  syndrome;
    logic        err_corr;
    logic        err_uncorr;
    logic [7:0]  corr_cnt;

    int nCompared   = 0;
    int nMismatched = 0;
    int expCnt      = 0;
    int dataPos[12] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17};
    vec_t vecs[$];

    ham_ser_dec #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sin_valid  (sin_valid),
        .sin_bit    (sin_bit),
        .sin_ready  (sin_ready),
        .frame_clr  (frame_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .esti_bits  (esti_bits),
        .syndrome   (syndrome),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr),
        .corr_cnt   (corr_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference decoder: per-group parity counts, then a table lookup of the
    // data positions.
    function automatic result_t modelDecode(input logic [16:0] cw);
        result_t     r;
        logic [16:0] fixed;
        int          s;
        int          cnt;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            cnt = 0;
            for (int k = 1; k <= 17; k++) begin
                if (((k >> i) % 2 == 1) && cw[k-1]) cnt++;
            end
            r.syn[i] = (cnt % 2 == 1);
        end
        s     = int'(r.syn);
        fixed = cw;
        r.corr = (s >= 1 && s <= 17);
        r.unc  = (s >= 18);
        if (r.corr) fixed[s-1] = ~fixed[s-1];
        for (int j = 0; j < 12; j++) r.esti[j] = fixed[dataPos[j]-1];
        return r;
    endfunction

    // Builds a valid even-parity codeword from 12 data bits.
    function automatic logic [16:0] encode(input logic [11:0] data);
        logic [16:0] cw;
        logic        par;
        int          p;
        cw = '0;
        for (int j = 0; j < 12; j++) cw[dataPos[j]-1] = data[j];
        for (int i = 0; i < 5; i++) begin
            p   = 1 << i;
            par = 1'b0;
            for (int k = 1; k <= 17; k++) begin
                if ((k & p) != 0) par = par ^ cw[k-1];
            end
            cw[p-1] = par;
        end
        return cw;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic waitReady();
        int t = 0;
        while (sin_ready !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) checkOutput("sin_ready wait timeout", 32'(sin_ready), 32'd1);
    endtask

    // Sends the first nBits bits of a frame, optionally with idle gaps.
    task automatic applyStimulus(input logic [16:0] frame, input int nBits, input bit gaps);
        for (int i = 0; i < nBits; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                sin_valid = 1'b0;
                sin_bit   = 1'($urandom);
                @(posedge clk);
                #1;
            end
            waitReady();
            sin_valid = 1'b1;
            sin_bit   = frame[i];
            @(posedge clk);
            #1;
        end
        sin_valid = 1'b0;
        sin_bit   = 1'b0;
    endtask

    task automatic runFrame(input string name, input logic [16:0] frame, input result_t exp, input bit gaps);
        int lat = 0;
        applyStimulus(frame, 17, gaps);
        checkOutput({name, " out_valid in CHECK"}, 32'(out_valid), 32'd0);
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'd1);
        if (exp.corr && expCnt < 255) expCnt++;
        checkOutput({name, " esti_bits"}, 32'(esti_bits), 32'(exp.esti));
        checkOutput({name, " syndrome"}, 32'(syndrome), 32'(exp.syn));
        checkOutput({name, " err_corr"}, 32'(err_corr), 32'(exp.corr));
        checkOutput({name, " err_uncorr"}, 32'(err_uncorr), 32'(exp.unc));
        checkOutput({name, " corr_cnt"}, 32'(corr_cnt), 32'(expCnt));
        checkOutput({name, " sin_ready in HOLD"}, 32'(sin_ready), 32'd0);
    endtask

    task automatic ackFrame(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, " out_valid after ack"}, 32'(out_valid), 32'd0);
        checkOutput({name, " sin_ready after ack"}, 32'(sin_ready), 32'd1);
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, " sin_ready"}, 32'(sin_ready), 32'd1);
        checkOutput({name, " out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, " esti_bits"}, 32'(esti_bits), 32'd0);
        checkOutput({name, " syndrome"}, 32'(syndrome), 32'd0);
        checkOutput({name, " err flags"}, 32'({err_corr, err_uncorr}), 32'd0);
        checkOutput({name, " corr_cnt"}, 32'(corr_cnt), 32'd0);
    endtask

    // Main test sequence.
    initial begin
        logic [16:0] cw;
        result_t     exp;
        int          p1;
        int          p2;

        reset_n   = 1'b0;
        sin_valid = 1'b0;
        sin_bit   = 1'b0;
        frame_clr = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back('{"clean",          17'h1FFFE, '{12'hFFF, 5'd0,  1'b0, 1'b0}});
        vecs.push_back('{"pos6 error",     17'h1FFDE, '{12'hFFF, 5'd6,  1'b1, 1'b0}});
        vecs.push_back('{"uncorr 19",      17'h08004, '{12'h001, 5'd19, 1'b0, 1'b1}});
        vecs.push_back('{"all zero",       17'h00000, '{12'h000, 5'd0,  1'b0, 1'b0}});
        vecs.push_back('{"pos1 parity",    17'h1FFFF, '{12'hFFF, 5'd1,  1'b1, 1'b0}});
        vecs.push_back('{"pos17 error",    17'h10000, '{12'h000, 5'd17, 1'b1, 1'b0}});
        vecs.push_back('{"syn17 miscorr",  17'h08001, '{12'h800, 5'd17, 1'b1, 1'b0}});
        vecs.push_back('{"uncorr 18",      17'h08002, '{12'h000, 5'd18, 1'b0, 1'b1}});

        out_ready = 1'b1;
        runFrame(vecs[0].name, vecs[0].frame, vecs[0].exp, 1'b0);
        out_ready = 1'b0;
        ackFrame(vecs[0].name);
        for (int v = 1; v < vecs.size(); v++) begin
            runFrame(vecs[v].name, vecs[v].frame, vecs[v].exp, 1'b0);
            ackFrame(vecs[v].name);
        end

        // Backpressure: HOLD must ignore serial bits and frame_clr.
        runFrame("bp frame", 17'h1FFDE, '{12'hFFF, 5'd6, 1'b1, 1'b0}, 1'b0);
        for (int c = 0; c < 10; c++) begin
            sin_valid = 1'b1;
            sin_bit   = 1'($urandom);
            frame_clr = (c == 4);
            @(posedge clk);
            #1;
            checkOutput("bp out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp sin_ready", 32'(sin_ready), 32'd0);
            checkOutput("bp held result", 32'({esti_bits, syndrome, err_corr}), 32'({12'hFFF, 5'd6, 1'b1}));
        end
        sin_valid = 1'b0;
        frame_clr = 1'b0;
        ackFrame("bp");
        runFrame("after bp", 17'h08004, '{12'h001, 5'd19, 1'b0, 1'b1}, 1'b0);
        ackFrame("after bp");

        // Abort with frame_clr, asserted together with a valid bit.
        applyStimulus(17'h1FFFF, 9, 1'b0);
        sin_valid = 1'b1;
        sin_bit   = 1'b1;
        frame_clr = 1'b1;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        frame_clr = 1'b0;
        runFrame("after clr", 17'h00000, '{12'h000, 5'd0, 1'b0, 1'b0}, 1'b0);
        ackFrame("after clr");

        // Abort with an asynchronous reset mid-frame.
        applyStimulus(17'h1FFFF, 9, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checkReset("mid-frame reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expCnt  = 0;
        runFrame("after reset", 17'h00000, '{12'h000, 5'd0, 1'b0, 1'b0}, 1'b0);
        ackFrame("after reset");

        // Reset while a corrected frame is held.
        runFrame("pre hold reset", 17'h1FFDE, '{12'hFFF, 5'd6, 1'b1, 1'b0}, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checkReset("hold reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expCnt  = 0;

        // Randomized frames with 0, 1 or 2 flipped positions and idle gaps.
        for (int n = 0; n < 40; n++) begin
            cw = encode(12'($urandom_range(0, 4095)));
            case ($urandom_range(0, 2))
                1: begin
                    p1 = $urandom_range(0, 16);
                    cw[p1] = ~cw[p1];
                end
                2: begin
                    p1 = $urandom_range(0, 16);
                    p2 = (p1 + $urandom_range(1, 16)) % 17;
                    cw[p1] = ~cw[p1];
                    cw[p2] = ~cw[p2];
                end
                default: ;
            endcase
            exp = modelDecode(cw);
            runFrame($sformatf("rand%0d", n), cw, exp, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            ackFrame($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Global time limit so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL global timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
